proj_router_writer: RTL

- Receiving end of the layer projection stream.
- Consumes phiL, zL and the three mutually-exclusive region flags (valid_projMinus / valid_proj / valid_projPlus) produced by the layer projection calculator.
- Packs each projection with its tracklet index and writes it into one of three downstream projection memories: minus neighbour, own sector, plus neighbour.
- Memories are double-buffered by event page. Per-page entry counts are published at each event boundary for the match engines.

---
 rtl/proj_router_writer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/proj_router_writer.sv
// proj_router_writer: packs layer projections with their tracklet index and writes them into
// double-buffered minus/own/plus projection memories. Optional macro: PROJ_ROUTER_DROPCNT_EN.
`default_nettype none

module proj_router_writer #(
    parameter int PHI_BITS  = 14,
    parameter int ADDR_BITS = 6,
    parameter int IDX_BITS  = 7
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [18:0]                     phiL,
    input  logic [11:0]                     zL,
    input  logic [IDX_BITS-1:0]             trklt_index,
    input  logic                            valid_proj,
    input  logic                            valid_projPlus,
    input  logic                            valid_projMinus,
    output logic                            wr_en_C,
    output logic                            wr_en_P,
    output logic                            wr_en_M,
    output logic [ADDR_BITS:0]              wr_addr_C,
    output logic [ADDR_BITS:0]              wr_addr_P,
    output logic [ADDR_BITS:0]              wr_addr_M,
    output logic [IDX_BITS+PHI_BITS+11:0]   wr_data,
    output logic [ADDR_BITS:0]              nproj_C,
    output logic [ADDR_BITS:0]              nproj_P,
    output logic [ADDR_BITS:0]              nproj_M,
    output logic                            nproj_valid,
    output logic                            overflow
`ifdef PROJ_ROUTER_DROPCNT_EN
    ,
    output logic [15:0]                     dropped_total
`endif
);

    localparam int CW = ADDR_BITS + 1;
    localparam logic [CW-1:0] FULL = CW'(2**ADDR_BITS);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]    state;
    logic [0:0]    state_nxt;
    logic          page;
    logic          page_eff;
    logic          active;
    logic          close;
    logic [2:0]    flags;
    logic [2:0]    acc;
    logic [2:0]    drop;
    logic [CW-1:0] cnt      [3];
    logic [CW-1:0] cnt_eff  [3];
    logic [CW-1:0] nproj    [3];
    logic [CW-1:0] addr     [3];
    logic [2:0]    en;
    logic          unused_bits;

    // Region order throughout: 0 = own sector (C), 1 = plus (P), 2 = minus (M).
    assign flags       = {valid_projMinus, valid_projPlus, valid_proj};
    assign unused_bits = ^phiL;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = S_RUN;
        end
    end

    // A start cycle already belongs to the new event: counters read as zero and the
    // page has flipped, so a coincident flag lands at entry 0 of the new page.
    always_comb begin
        active   = (state == S_RUN) || start;
        close    = start && (state == S_RUN);
        page_eff = close ? ~page : page;
        for (int r = 0; r < 3; r++) begin
            cnt_eff[r] = start ? '0 : cnt[r];
            acc[r]     = active && flags[r] && (cnt_eff[r] != FULL);
            drop[r]    = active && flags[r] && (cnt_eff[r] == FULL);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            page        <= 1'b0;
            overflow    <= 1'b0;
            nproj_valid <= 1'b0;
            wr_data     <= '0;
        end else begin
            page        <= page_eff;
            overflow    <= (overflow && !start) || (|drop);
            nproj_valid <= close;
            if (|acc) begin
                wr_data <= {trklt_index, phiL[16:17-PHI_BITS], zL};
            end
        end
    end

    for (genvar r = 0; r < 3; r++) begin : g_region
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt[r]   <= '0;
                en[r]    <= 1'b0;
                addr[r]  <= '0;
                nproj[r] <= '0;
            end else begin
                en[r]  <= acc[r];
                cnt[r] <= acc[r] ? cnt_eff[r] + 1'b1 : cnt_eff[r];
                if (acc[r]) begin
                    addr[r] <= {page_eff, cnt_eff[r][ADDR_BITS-1:0]};
                end
                if (close) begin
                    nproj[r] <= cnt[r];
                end
            end
        end
    end

    assign wr_en_C   = en[0];
    assign wr_en_P   = en[1];
    assign wr_en_M   = en[2];
    assign wr_addr_C = addr[0];
    assign wr_addr_P = addr[1];
    assign wr_addr_M = addr[2];
    assign nproj_C   = nproj[0];
    assign nproj_P   = nproj[1];
    assign nproj_M   = nproj[2];

`ifdef PROJ_ROUTER_DROPCNT_EN
    logic [1:0]  drop_n;
    logic [16:0] drop_sum;

    assign drop_n   = 2'(drop[0]) + 2'(drop[1]) + 2'(drop[2]);
    assign drop_sum = {1'b0, dropped_total} + 17'(drop_n);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dropped_total <= '0;
        end else begin
            dropped_total <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end
`endif

endmodule

`default_nettype wire
